muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit with architectural HI/LO registers. It extends the single-cycle MIPS core with MULT, MULTU, DIV, DIVU, MTHI and MTLO. The unit sits beside the ALU. The core stalls its PC while busy is high and reads hi/lo for MFHI/MFLO. Radix-2 shift-add multiply and restoring divide, one bit per cycle.

---
 rtl/muldiv_unit.sv | 166 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 multiply/restoring divide unit with HI/LO registers
// Optional MULDIV_EARLY_OUT_EN: zero operands bypass the iteration phase.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic             sign_a;
    logic             sign_b;
    logic             is_div;
    logic             div_zero;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             b_is_zero;
    logic             early;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // ops 0 (MULT) and 2 (DIV) are the signed variants
    assign signed_op = ~op[0];
    assign a_neg     = signed_op & a[WIDTH-1];
    assign b_neg     = signed_op & b[WIDTH-1];
    assign a_mag     = a_neg ? (~a + 1'b1) : a;
    assign b_mag     = b_neg ? (~b + 1'b1) : b;
    assign b_is_zero = (b == '0);

`ifdef MULDIV_EARLY_OUT_EN
    assign early = (a == '0) || b_is_zero;
`else
    assign early = 1'b0;
`endif

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};

    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = (sign_a ^ sign_b) ? (~prod + 1'b1) : prod;
    assign quo_fix  = (sign_a ^ sign_b) ? (~acc_lo + 1'b1) : acc_lo;
    assign rem_fix  = sign_a ? (~acc_hi + 1'b1) : acc_hi;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !op[2]) begin
                            sign_a   <= a_neg;
                            sign_b   <= b_neg;
                            is_div   <= op[1];
                            div_zero <= op[1] & b_is_zero;
                            count    <= CW'(WIDTH);
                            busy     <= 1'b1;
                            state    <= early ? S_FIX : S_CALC;
                            if (op[1]) begin
                                opnd <= b_mag;
                                // a zero divisor parks |a| as remainder and all-ones as quotient
                                if (b_is_zero) begin
                                    acc_hi <= a_mag;
                                    acc_lo <= '1;
                                end else begin
                                    acc_hi <= '0;
                                    acc_lo <= early ? '0 : a_mag;
                                end
                            end else begin
                                opnd   <= a_mag;
                                acc_hi <= '0;
                                acc_lo <= early ? '0 : b_mag;
                            end
                        end else if (start && op == 3'd4) begin
                            hi <= a;
                        end else if (start && op == 3'd5) begin
                            lo <= a;
                        end
                    end
                    S_CALC: begin
                        if (!is_div) begin
                            {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                        end else if (!div_zero) begin
                            if (div_diff[WIDTH]) begin
                                acc_hi <= div_shift[WIDTH-1:0];
                                acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                            end else begin
                                acc_hi <= div_diff[WIDTH-1:0];
                                acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                            end
                        end
                        count <= count - 1'b1;
                        if (count == CW'(1)) begin
                            state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= div_zero ? '1 : quo_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                        count <= '0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks;
    int errors;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {hi, lo} as defined by the architectural rules, using plain integer arithmetic
    function automatic logic [63:0] ref_model(input logic [2:0] rop, input logic [31:0] ra, input logic [31:0] rb);
        longint p;
        int     sa;
        int     sb;
        int     q;
        int     r;
        sa = int'(ra);
        sb = int'(rb);
        case (rop)
            3'd0: begin
                p = longint'(sa) * longint'(sb);
                return p;
            end
            3'd1: return {32'h0, ra} * {32'h0, rb};
            3'd2: begin
                if (rb == 0) return {ra, 32'hFFFF_FFFF};
                if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (rb == 0) return {ra, 32'hFFFF_FFFF};
                return {ra % rb, ra / rb};
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [31:0] ra, input logic [31:0] rb);
`ifdef MULDIV_EARLY_OUT_EN
        if (ra == 0 || rb == 0) return 2;
`endif
        return W + 2;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    // Issue a mul/div in the current cycle k and check busy, latency and result.
    task automatic do_op(input string tag, input logic [2:0] top, input logic [31:0] ta, input logic [31:0] tb);
        logic [63:0] exp;
        int          n;
        exp   = ref_model(top, ta, tb);
        start = 1'b1;
        op    = top;
        a     = ta;
        b     = tb;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        n     = 1;
        check({tag, " busy k+1"}, 64'(busy), 64'(1));
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(exp_latency(ta, tb)));
        check({tag, " hi"}, 64'(hi), 64'(exp[63:32]));
        check({tag, " lo"}, 64'(lo), 64'(exp[31:0]));
        check({tag, " busy at done"}, 64'(busy), 64'(0));
        @(negedge clk);
        check({tag, " done pulse"}, 64'(done), 64'(0));
    endtask

    initial begin
        logic [63:0] exp;
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rop;
        int          n;
        int          seen_done;

        checks = 0;
        errors = 0;
        rst    = 1'b0;
        start  = 1'b0;
        op     = 3'd0;
        a      = '0;
        b      = '0;
        flush  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset hi", 64'(hi), 64'(0));
        check("reset lo", 64'(lo), 64'(0));
        rst = 1'b1;
        @(negedge clk);

        do_op("multu max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu max hi const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        do_op("mult -3*7", 3'd0, 32'hFFFF_FFFD, 32'h0000_0007);
        check("mult -3*7 lo const", 64'(lo), 64'h0000_0000_FFFF_FFEB);
        do_op("div -7/2", 3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
        check("div -7/2 lo const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
        do_op("divu by zero", 3'd3, 32'h0000_0064, 32'h0);
        do_op("div neg by zero", 3'd2, 32'hFFFF_FF00, 32'h0);
        do_op("div overflow", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("mult zero", 3'd0, 32'h0, 32'h1234_5678);
        do_op("div zero dividend", 3'd2, 32'h0, 32'hFFFF_FFFB);

        // start while busy must be ignored
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        repeat (4) begin @(negedge clk); n++; end
        start = 1'b1; op = 3'd1; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        @(negedge clk);
        n++;
        start = 1'b0;
        while (!done && n < 200) begin @(negedge clk); n++; end
        check("ignored start latency", 64'(n), 64'(W + 2));
        check("ignored start lo", 64'(lo), 64'h0000_000E);
        check("ignored start hi", 64'(hi), 64'h0000_0002);
        @(negedge clk);

        // flush mid-operation at k+10
        start = 1'b1; op = 3'd0; a = 32'h0000_1111; b = 32'h0000_2222;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'(0));
        seen_done = 0;
        repeat (W + 4) begin @(negedge clk); if (done) seen_done = 1; end
        check("flush no done", 64'(seen_done), 64'(0));
        check("flush hold hi", 64'(hi), 64'h0000_0002);
        check("flush hold lo", 64'(lo), 64'h0000_000E);

        // flush coinciding with the FIX cycle suppresses the write
        start = 1'b1; op = 3'd1; a = 32'h0000_0003; b = 32'h0000_0005;
        @(negedge clk);
        start = 1'b0;
        repeat (W) @(negedge clk);
        check("fix cycle busy", 64'(busy), 64'(1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush fix done", 64'(done), 64'(0));
        check("flush fix busy", 64'(busy), 64'(0));
        check("flush fix hi", 64'(hi), 64'h0000_0002);
        check("flush fix lo", 64'(lo), 64'h0000_000E);

        // flush in idle drops a simultaneous start
        start = 1'b1; op = 3'd4; a = 32'hCAFE_F00D; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("idle flush busy", 64'(busy), 64'(0));
        check("idle flush mthi dropped", 64'(hi), 64'h0000_0002);

        // MTHI / MTLO, and op 6/7 no-ops
        seen_done = 0;
        start = 1'b1; op = 3'd4; a = 32'h1234_5678;
        @(negedge clk);
        if (done) seen_done = 1;
        check("mthi hi", 64'(hi), 64'h1234_5678);
        check("mthi busy", 64'(busy), 64'(0));
        op = 3'd5; a = 32'h9ABC_DEF0;
        @(negedge clk);
        if (done) seen_done = 1;
        check("mtlo lo", 64'(lo), 64'h9ABC_DEF0);
        op = 3'd6; a = 32'h5555_5555; b = 32'h3;
        @(negedge clk);
        if (done) seen_done = 1;
        op = 3'd7;
        @(negedge clk);
        if (done) seen_done = 1;
        start = 1'b0;
        check("nop busy", 64'(busy), 64'(0));
        check("nop hi", 64'(hi), 64'h1234_5678);
        check("nop lo", 64'(lo), 64'h9ABC_DEF0);
        check("move no done", 64'(seen_done), 64'(0));

        // randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = pick_operand();
            rb  = pick_operand();
            do_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
        end

        // asynchronous reset in the middle of a multiply
        exp = ref_model(3'd1, 32'h7, 32'h9);
        do_op("pre-reset multu", 3'd1, 32'h7, 32'h9);
        check("pre-reset lo", 64'(lo), exp & 64'hFFFF_FFFF);
        start = 1'b1; op = 3'd0; a = 32'hFFFF_0001; b = 32'h0001_FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        hold_hi = hi;
        hold_lo = lo;
        check("pre-reset hold", {hold_hi, hold_lo}, exp);
        rst = 1'b0;
        #1;
        check("reset mid hi", 64'(hi), 64'(0));
        check("reset mid lo", 64'(lo), 64'(0));
        check("reset mid busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_op("post-reset divu", 3'd3, 32'd1000, 32'd33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
